// File: rtl/phase_ctrl.sv
// phase_ctrl: multi-cycle instruction sequencer (fetch / decode / execute / memory).
// Steps the datapath through its phases, issues Mealy strobes for the IR, PC, RF and
// memory port, counts retired instructions and traps to a sticky fault on memory timeout.
module phase_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_rdy,
  input  logic                 op_mem,
  input  logic                 op_st,
  input  logic                 op_wb,
  input  logic                 op_br,
  input  logic                 cond,
  input  logic                 op_halt,
  input  logic                 run,
  output logic                 fetch_req,
  output logic                 data_req,
  output logic                 data_wr,
  output logic                 ic_en,
  output logic                 pc_inc,
  output logic                 pc_ld,
  output logic                 rf_we,
  output logic                 halted,
  output logic                 fault,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout;
  logic              retire;
  logic              wait_inc;

  assign state = cur;

  // Memory wait bound reached; a zero bound never expires.
  assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // State register, memory wait counter and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      cur <= nxt;
      if (nxt != cur) begin
        wait_cnt <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        instret <= instret + CNT_WIDTH'(1);
      end
    end
  end

  // Next-state and Mealy strobe decode; reset masks every strobe.
  always_comb begin
    nxt       = cur;
    retire    = 1'b0;
    wait_inc  = 1'b0;
    fetch_req = 1'b0;
    data_req  = 1'b0;
    data_wr   = 1'b0;
    ic_en     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    rf_we     = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (cur)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (mem_rdy) begin
          ic_en  = 1'b1;
          pc_inc = 1'b1;
          nxt    = S_DECODE;
        end else if (timeout) begin
          nxt = S_FAULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        if (op_halt) begin
          nxt    = S_HALT;
          retire = 1'b1;
        end else if (op_mem) begin
          nxt = S_MEM;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        rf_we  = op_wb;
        pc_ld  = op_br & cond;
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_MEM: begin
        data_req = 1'b1;
        data_wr  = op_st;
        if (mem_rdy) begin
          rf_we  = ~op_st;
          nxt    = S_FETCH;
          retire = 1'b1;
        end else if (timeout) begin
          nxt = S_FAULT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (run) begin
          nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        nxt = S_FAULT;
      end
    endcase
    if (reset) begin
      fetch_req = 1'b0;
      data_req  = 1'b0;
      data_wr   = 1'b0;
      ic_en     = 1'b0;
      pc_inc    = 1'b0;
      pc_ld     = 1'b0;
      rf_we     = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl: table-driven vectors, hand-written corner sequences and a randomized
// run against a behavioural model of the phase sequencer.
module tb_phase_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rdy, op_mem, op_st, op_wb, op_br, cond, op_halt, run;
  logic        fetch_req, data_req, data_wr, ic_en, pc_inc, pc_ld, rf_we, halted, fault;
  logic [2:0]  state;
  logic [15:0] instret;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  phase_ctrl #(.MEM_TIMEOUT(15), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mem_rdy(mem_rdy), .op_mem(op_mem), .op_st(op_st),
    .op_wb(op_wb), .op_br(op_br), .cond(cond), .op_halt(op_halt), .run(run),
    .fetch_req(fetch_req), .data_req(data_req), .data_wr(data_wr), .ic_en(ic_en),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .rf_we(rf_we), .halted(halted), .fault(fault),
    .state(state), .instret(instret)
  );

  // inputs packed as {reset,mem_rdy,op_mem,op_st,op_wb,op_br,cond,op_halt,run}
  // strobes packed as {fetch_req,data_req,data_wr,ic_en,pc_inc,pc_ld,rf_we,halted,fault}
  typedef struct packed {
    logic [8:0]  in;
    logic [2:0]  e_state;
    logic [8:0]  e_str;
    logic [15:0] e_inst;
  } vec_t;

  function automatic vec_t row(input logic [8:0] i, input logic [2:0] s,
                               input logic [8:0] st, input logic [15:0] n);
    vec_t v;
    v.in = i; v.e_state = s; v.e_str = st; v.e_inst = n;
    return v;
  endfunction

  function automatic logic [8:0] strobes();
    return {fetch_req, data_req, data_wr, ic_en, pc_inc, pc_ld, rf_we, halted, fault};
  endfunction

  task automatic drive(input logic [8:0] i);
    {reset, mem_rdy, op_mem, op_st, op_wb, op_br, cond, op_halt, run} = i;
  endtask

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got state=%0d str=%b inst=%0d, want state=%0d str=%b inst=%0d",
               name, act[27:25], act[24:16], act[15:0], exp[27:25], exp[24:16], exp[15:0]);
    end
  endtask

  // One cycle: drive, sample at falling edge, compare, advance past the rising edge.
  task automatic cyc(input string name, input logic [8:0] i, input logic [2:0] s,
                     input logic [8:0] st, input logic [15:0] n);
    drive(i);
    @(negedge clk);
    check(name, {state, strobes(), instret}, {s, st, n});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(9'b1_0000_0000);
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phase code, waited cycles, retired count.
  int          m_ph;
  int          m_wait;
  logic [15:0] m_ret;

  function automatic logic [8:0] model_out(input logic [8:0] i);
    logic rs, rd, mm, st, wb, br, cd, hl, rn;
    {rs, rd, mm, st, wb, br, cd, hl, rn} = i;
    if (rs) return 9'b0;
    case (m_ph)
      0: return {1'b1, 2'b00, rd, rd, 4'b0000};
      2: return {5'b00000, br & cd, wb, 2'b00};
      3: return {1'b0, 1'b1, st, 3'b000, rd & ~st, 2'b00};
      4: return 9'b0_0000_0010;
      5: return 9'b0_0000_0001;
      default: return 9'b0;
    endcase
  endfunction

  task automatic model_step(input logic [8:0] i);
    int nph;
    logic rs, rd, mm, hl, rn;
    rs = i[8]; rd = i[7]; mm = i[6]; hl = i[1]; rn = i[0];
    nph = m_ph;
    if (rs) begin
      m_ph = 0; m_wait = 0; m_ret = '0;
      return;
    end
    case (m_ph)
      0, 3: begin
        if (rd) begin
          nph = (m_ph == 0) ? 1 : 0;
          if (m_ph == 3) m_ret++;
        end else if (m_wait == 15) nph = 5;
      end
      1: begin
        if (hl) begin nph = 4; m_ret++; end
        else nph = mm ? 3 : 2;
      end
      2: begin nph = 0; m_ret++; end
      4: if (rn) nph = 0;
      default: ;
    endcase
    m_wait = (nph != m_ph) ? 0 : m_wait + 1;
    m_ph = nph;
  endtask

  vec_t tbl[$];

  initial begin
    drive(9'b1_0000_0000);
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(row(9'b1_1000_0000, 3'd0, 9'b0_0000_0000, 16'd0));
    tbl.push_back(row(9'b0_1001_0000, 3'd0, 9'b1_0011_0000, 16'd0));
    tbl.push_back(row(9'b0_0000_0000, 3'd1, 9'b0_0000_0000, 16'd0));
    tbl.push_back(row(9'b0_0001_1100, 3'd2, 9'b0_0000_1100, 16'd0));
    tbl.push_back(row(9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd1));
    tbl.push_back(row(9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd1));
    tbl.push_back(row(9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd1));
    tbl.push_back(row(9'b0_0100_0000, 3'd1, 9'b0_0000_0000, 16'd1));
    tbl.push_back(row(9'b0_0100_0000, 3'd3, 9'b0_1000_0000, 16'd1));
    tbl.push_back(row(9'b0_1100_0000, 3'd3, 9'b0_1000_0100, 16'd1));
    tbl.push_back(row(9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd2));
    tbl.push_back(row(9'b0_0110_0000, 3'd1, 9'b0_0000_0000, 16'd2));
    tbl.push_back(row(9'b0_1110_0000, 3'd3, 9'b0_1100_0000, 16'd2));
    tbl.push_back(row(9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd3));
    tbl.push_back(row(9'b0_0100_0010, 3'd1, 9'b0_0000_0000, 16'd3));
    tbl.push_back(row(9'b0_1000_0000, 3'd4, 9'b0_0000_0010, 16'd4));
    tbl.push_back(row(9'b0_0000_0001, 3'd4, 9'b0_0000_0010, 16'd4));
    tbl.push_back(row(9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd4));
    tbl.push_back(row(9'b0_0000_0000, 3'd1, 9'b0_0000_0000, 16'd4));
    tbl.push_back(row(9'b0_0000_1000, 3'd2, 9'b0_0000_0000, 16'd4));
    tbl.push_back(row(9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd5));
    tbl.push_back(row(9'b1_1000_0000, 3'd0, 9'b0_0000_0000, 16'd5));
    tbl.push_back(row(9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd0));

    foreach (tbl[k]) begin
      cyc($sformatf("table[%0d]", k), tbl[k].in, tbl[k].e_state, tbl[k].e_str, tbl[k].e_inst);
    end

    // Fetch timeout: 16 FETCH cycles without rdy, then sticky FAULT until reset.
    do_reset();
    for (int k = 0; k < 16; k++) cyc("timeout_wait", 9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd0);
    for (int k = 0; k < 4; k++) cyc("fault_sticky", 9'b0_1000_0001, 3'd5, 9'b0_0000_0001, 16'd0);
    cyc("fault_reset", 9'b1_1000_0000, 3'd5, 9'b0_0000_0000, 16'd0);
    cyc("after_fault_reset", 9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd0);

    // rdy at the last allowed wait cycle wins over the timeout.
    do_reset();
    for (int k = 0; k < 15; k++) cyc("late_rdy_wait", 9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd0);
    cyc("late_rdy", 9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd0);
    cyc("late_rdy_decode", 9'b0_0000_0000, 3'd1, 9'b0_0000_0000, 16'd0);

    // MEM timeout after a data request that never completes.
    cyc("mem_t_exec", 9'b0_0000_0000, 3'd2, 9'b0_0000_0000, 16'd0);
    cyc("mem_t_fetch", 9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd1);
    cyc("mem_t_decode", 9'b0_0110_0000, 3'd1, 9'b0_0000_0000, 16'd1);
    for (int k = 0; k < 16; k++) cyc("mem_t_wait", 9'b0_0010_0000, 3'd3, 9'b0_1100_0000, 16'd1);
    cyc("mem_t_fault", 9'b0_0000_0000, 3'd5, 9'b0_0000_0001, 16'd1);

    // HALT holds with no strobes, then reset clears state and count.
    do_reset();
    cyc("halt_fetch", 9'b0_1000_0000, 3'd0, 9'b1_0011_0000, 16'd0);
    cyc("halt_decode", 9'b0_0000_0010, 3'd1, 9'b0_0000_0000, 16'd0);
    for (int k = 0; k < 10; k++) begin
      cyc("halt_hold", {1'b0, 7'($urandom), 1'b0}, 3'd4, 9'b0_0000_0010, 16'd1);
    end
    cyc("halt_reset", 9'b1_0000_0000, 3'd4, 9'b0_0000_0000, 16'd1);
    cyc("halt_after_reset", 9'b0_0000_0000, 3'd0, 9'b1_0000_0000, 16'd0);

    // Randomized run against the model, memory readiness varying by segment.
    do_reset();
    m_ph = 0; m_wait = 0; m_ret = '0;
    for (int seg = 0; seg < 30; seg++) begin
      int pct;
      case ($urandom_range(3))
        0: pct = 0;
        1: pct = 10;
        2: pct = 50;
        default: pct = 90;
      endcase
      for (int k = 0; k < 100; k++) begin
        logic [8:0] i;
        i = 9'($urandom);
        i[8] = ($urandom_range(99) == 0);
        i[7] = ($urandom_range(99) < pct);
        i[0] = ($urandom_range(7) == 0);
        cyc("random", i, m_ph[2:0], model_out(i), m_ret);
        model_step(i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_ctrl.md
Name: phase_ctrl

Overview:
Multi-cycle instruction sequencer for the 32-bit CPU core. It steps the datapath through fetch, decode, execute and memory phases, and drives the enables for the instruction register, program counter, register file and memory port. Decode flags come from the instruction register's outputs. The memory port uses a rdy handshake with a bounded wait and traps to a sticky fault state on timeout.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_rdy in FETCH/MEM; 0 disables timeout; legal range 0..255
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
mem_rdy  input  1  memory completes current request this cycle
op_mem  input  1  decoded: load/store instruction
op_st  input  1  decoded: store (valid when op_mem=1)
op_wb  input  1  decoded: ALU result written to register file
op_br  input  1  decoded: branch/jump
cond  input  1  branch condition true (ALU flag)
op_halt  input  1  decoded: halt instruction
run  input  1  resume from HALT
fetch_req  output  1  instruction-fetch request to memory
data_req  output  1  data-access request to memory
data_wr  output  1  data access is a write (qualifies data_req)
ic_en  output  1  load instruction register
pc_inc  output  1  increment PC
pc_ld  output  1  load PC with branch target
rf_we  output  1  register-file write enable
halted  output  1  core in HALT state
fault  output  1  memory timeout trap, sticky
state  output  3  current state code (debug)
instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Clocking and reset: one clock domain, clk. reset is synchronous and active-high. While reset=1 at a clk edge: state<=FETCH (0), wait_cnt<=0, instret<=0. During any cycle with reset=1, all strobe outputs are forced to 0.
- Reset values: fetch_req, data_req, data_wr, ic_en, pc_inc, pc_ld, rf_we, halted and fault are all 0; state=0; instret=0.
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4, FAULT=5. Codes 6 and 7 are unreachable; if entered, go to FAULT.
- Output decoding: outputs are combinational from state and inputs (Mealy strobes); state and counters are registered.
- FETCH:
  - fetch_req=1.
  - If mem_rdy=1: ic_en=1 and pc_inc=1 in the same cycle, next state DECODE.
  - Else wait_cnt++; if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, next state FAULT.
- DECODE: exactly one cycle, no strobes. Priority is op_halt > op_mem > other.
  - op_halt -> HALT.
  - op_mem -> MEM.
  - otherwise -> EXEC.
- EXEC: exactly one cycle.
  - rf_we=op_wb; pc_ld=op_br&cond.
  - Next state FETCH; instret++.
- MEM:
  - data_req=1; data_wr=op_st.
  - If mem_rdy=1: rf_we=~op_st (a load writes back in the rdy cycle), next state FETCH, instret++.
  - Timeout rule is identical to FETCH.
- HALT:
  - halted=1, no strobes.
  - run=1 -> FETCH. Entry into HALT counts as one retired instruction (instret++ on the DECODE->HALT transition).
- FAULT: fault=1, no strobes, no exit except reset.
- wait_cnt: 8-bit, cleared on every state transition. If mem_rdy and the timeout condition occur in the same cycle, mem_rdy wins.
- Branch taken: pc_inc in FETCH precedes pc_ld in EXEC, so the target overrides.
- Latencies with zero-wait memory: ALU instruction 3 cycles (F,D,E); load/store 3 cycles (F,D,M).
- instret wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-operation (including in HALT or FAULT): state returns to FETCH on the next edge, and any request in flight is dropped.
- Inputs op_* and cond are sampled only in the states listed above; they are don't-care elsewhere.

Test Plan:
- Reset then mem_rdy=1 constant with op_wb=1: state sequence 0,1,2,0,...; ic_en and pc_inc high in cycles 1,4,7; rf_we high in cycles 3,6,...; instret=3 after 9 cycles.
- Fetch with mem_rdy delayed 4 cycles: fetch_req held 5 cycles; ic_en pulses exactly once, in the rdy cycle; wait_cnt cleared on entry to DECODE.
- Load (op_mem=1, op_st=0) with rdy on the 2nd MEM cycle: data_req=1 and data_wr=0 for 2 cycles; rf_we=1 only in the rdy cycle. A store (op_st=1) gives data_wr=1 and rf_we=0 throughout.
- Branch op_br=1: with cond=1, pc_ld=1 in the EXEC cycle; with cond=0, pc_ld=0. pc_inc never coincides with pc_ld.
- MEM_TIMEOUT=15, mem_rdy=0 in FETCH: after 15 wait cycles state=5 and fault=1 stays set. mem_rdy arriving at wait_cnt==15 goes to DECODE instead. A reset pulse then returns state=0 and fault=0.
- op_halt in DECODE: state=4, halted=1, instret incremented, no strobes for 10 cycles. run=1 -> FETCH next cycle. Reset asserted while in HALT -> state 0 and instret 0.
